// File: rtl/dmem_arb.sv
// Two-master data-memory arbiter. Grants one access per cycle, bounds
// consecutive grants to MAX_BURST under contention and routes read-valid back.
module dmem_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_en,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_d,
  input  logic [3:0]  m0_we,
  output logic        m0_gnt,
  output logic [31:0] m0_q,
  output logic        m0_rvalid,
  input  logic        m1_en,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_d,
  input  logic [3:0]  m1_we,
  output logic        m1_gnt,
  output logic [31:0] m1_q,
  output logic        m1_rvalid,
  output logic        s_en,
  output logic [31:0] s_addr,
  output logic [31:0] s_d,
  output logic [3:0]  s_we,
  input  logic [31:0] s_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_C = 4'(MAX_BURST);

  owner_e     owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rr_q, rr_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;
  logic       gnt0_s, gnt1_s;

  // Grant selection from live requests and ownership history.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (m0_en && m1_en) begin
      case (owner_q)
        OWN0: begin
          if (cnt_q < MAX_C) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        OWN1: begin
          if (cnt_q < MAX_C) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end
        default: begin
          if (rr_q) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end
      endcase
    end else if (m0_en) begin
      gnt0_s = 1'b1;
    end else if (m1_en) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Slave bus mux; address/data forced to zero when idle for determinism.
  always_comb begin
    s_en   = 1'b0;
    s_addr = 32'h0000_0000;
    s_d    = 32'h0000_0000;
    s_we   = 4'b0000;
    if (gnt0_s) begin
      s_en   = 1'b1;
      s_addr = m0_addr;
      s_d    = m0_d;
      s_we   = m0_we;
    end else if (gnt1_s) begin
      s_en   = 1'b1;
      s_addr = m1_addr;
      s_d    = m1_d;
      s_we   = m1_we;
    end else begin
      s_en   = 1'b0;
    end
  end

  // Next-state for ownership, burst count, round-robin and read tracking.
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    if (gnt0_s) begin
      owner_d   = OWN0;
      rr_d      = 1'b1;
      rd_pend_d = (m0_we == 4'b0000);
      rd_id_d   = 1'b0;
      if (owner_q == OWN0) begin
        cnt_d = (cnt_q >= MAX_C) ? MAX_C : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end else if (gnt1_s) begin
      owner_d   = OWN1;
      rr_d      = 1'b0;
      rd_pend_d = (m1_we == 4'b0000);
      rd_id_d   = 1'b1;
      if (owner_q == OWN1) begin
        cnt_d = (cnt_q >= MAX_C) ? MAX_C : cnt_q + 4'd1;
      end else begin
        cnt_d = 4'd1;
      end
    end else begin
      owner_d = IDLE;
      cnt_d   = 4'd0;
    end
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= IDLE;
      cnt_q     <= 4'd0;
      rr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign m0_gnt    = gnt0_s;
  assign m1_gnt    = gnt1_s;
  assign m0_q      = s_q;
  assign m1_q      = s_q;
  assign m0_rvalid = rd_pend_q && (rd_id_q == 1'b0);
  assign m1_rvalid = rd_pend_q && (rd_id_q == 1'b1);

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: a vector table plus burst, saturation and
// mid-read reset sequences.
module tb_dmem_arb;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  localparam logic [31:0] D0 = 32'hA5A5_0000;
  localparam logic [31:0] D1 = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_en = 1'b0, m1_en = 1'b0;
  logic [31:0] m0_addr = A0, m1_addr = A1, m0_d = D0, m1_d = D1;
  logic [3:0]  m0_we = 4'b0000, m1_we = 4'b0000;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_en;
  logic [31:0] m0_q, m1_q, s_addr, s_d, s_q = 32'h0;
  logic [3:0]  s_we;

  int total = 0;
  int bad = 0;

  dmem_arb #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_en(m0_en), .m0_addr(m0_addr), .m0_d(m0_d), .m0_we(m0_we),
    .m0_gnt(m0_gnt), .m0_q(m0_q), .m0_rvalid(m0_rvalid),
    .m1_en(m1_en), .m1_addr(m1_addr), .m1_d(m1_d), .m1_we(m1_we),
    .m1_gnt(m1_gnt), .m1_q(m1_q), .m1_rvalid(m1_rvalid),
    .s_en(s_en), .s_addr(s_addr), .s_d(s_d), .s_we(s_we), .s_q(s_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_en = 1'b0; m1_en = 1'b0; m0_we = 4'b0000; m1_we = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        e0, e1;
    logic [3:0]  we0, we1;
    logic [31:0] sq;
    logic        g0, g1, rv0, rv1;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic        xg0, xg1;
    logic [3:0]  xwe;
    logic [31:0] xa, xd;

    //         e0    e1    we0      we1      s_q            g0    g1    rv0   rv1
    tbl[0]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h3333_3333, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h4444_4444, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 4'b1111, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 32'h6666_6666, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 32'h8888_8888, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 32'h9999_9999, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'b0011, 4'b0000, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 32'hCCCC_CCCC, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n = 1'b0;
    #2;
    chk("reset_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("reset_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("reset_sen", {31'd0, s_en}, 32'd0);
    do_reset();

    // Vector table, applied one per cycle with state carried across rows
    for (int i = 0; i < 14; i++) begin
      m0_en = tbl[i].e0; m1_en = tbl[i].e1;
      m0_we = tbl[i].we0; m1_we = tbl[i].we1;
      s_q = tbl[i].sq;
      @(negedge clk);
      xg0 = tbl[i].g0;
      xg1 = tbl[i].g1;
      xwe = xg0 ? tbl[i].we0 : (xg1 ? tbl[i].we1 : 4'b0000);
      chk($sformatf("v%0d_g0", i), {31'd0, m0_gnt}, {31'd0, xg0});
      chk($sformatf("v%0d_g1", i), {31'd0, m1_gnt}, {31'd0, xg1});
      chk($sformatf("v%0d_sen", i), {31'd0, s_en}, {31'd0, xg0 | xg1});
      chk($sformatf("v%0d_swe", i), {28'd0, s_we}, {28'd0, xwe});
      if (xg0 || xg1) begin
        xa = xg0 ? A0 : A1;
        xd = xg0 ? D0 : D1;
        chk($sformatf("v%0d_saddr", i), s_addr, xa);
        chk($sformatf("v%0d_sd", i), s_d, xd);
      end
      chk($sformatf("v%0d_rv0", i), {31'd0, m0_rvalid}, {31'd0, tbl[i].rv0});
      chk($sformatf("v%0d_rv1", i), {31'd0, m1_rvalid}, {31'd0, tbl[i].rv1});
      chk($sformatf("v%0d_q0", i), m0_q, tbl[i].sq);
      chk($sformatf("v%0d_q1", i), m1_q, tbl[i].sq);
      @(posedge clk);
      #1;
    end

    // Continuous contention: 0000111100001111
    do_reset();
    m0_en = 1'b1; m1_en = 1'b1; m0_we = 4'b0000; m1_we = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      xg1 = ((i / 4) % 2) == 1;
      chk($sformatf("burst%0d_g1", i), {31'd0, m1_gnt}, {31'd0, xg1});
      chk($sformatf("burst%0d_g0", i), {31'd0, m0_gnt}, {31'd0, ~xg1});
      chk($sformatf("burst%0d_addr", i), s_addr, xg1 ? A1 : A0);
      @(posedge clk);
      #1;
    end

    // m0 alone saturates its count, then m1 joins and must win at once
    do_reset();
    m0_en = 1'b1; m1_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("solo%0d_g0", i), {31'd0, m0_gnt}, 32'd1);
      @(posedge clk);
      #1;
    end
    m1_en = 1'b1;
    @(negedge clk);
    chk("join_g1", {31'd0, m1_gnt}, 32'd1);
    chk("join_g0", {31'd0, m0_gnt}, 32'd0);
    @(posedge clk);
    #1;

    // Reset asserted one cycle after a granted read
    do_reset();
    m1_en = 1'b0; m0_en = 1'b1; m0_we = 4'b0000;
    @(negedge clk);
    chk("rr_read_g0", {31'd0, m0_gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rv0", {31'd0, m0_rvalid}, 32'd0);
    chk("rst_mid_rv1", {31'd0, m1_rvalid}, 32'd0);
    chk("rst_comb_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_rv0", i), {31'd0, m0_rvalid}, 32'd0);
      chk($sformatf("post_rst%0d_rv1", i), {31'd0, m1_rvalid}, 32'd0);
      @(posedge clk);
      #1;
    end
    m0_en = 1'b1; m1_en = 1'b1;
    @(negedge clk);
    chk("post_rst_g0", {31'd0, m0_gnt}, 32'd1);
    chk("post_rst_g1", {31'd0, m1_gnt}, 32'd0);
    @(posedge clk);
    #1;
    m0_en = 1'b0; m1_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: the maximum number of consecutive grants to one master while the other master is requesting (legal range 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port m0_en  input  1  master 0 (CPU dmem port) access request, valid for one cycle per access.
REQ-005 SHALL have port m0_addr  input  32  master 0 byte address.
REQ-006 SHALL have port m0_d  input  32  master 0 write data.
REQ-007 SHALL have port m0_we  input  4  master 0 byte write enables; 4'b0000 means read.
REQ-008 SHALL have port m0_gnt  output  1  master 0 access accepted this cycle.
REQ-009 SHALL have port m0_q  output  32  master 0 read data.
REQ-010 SHALL have port m0_rvalid  output  1  m0_q holds the data for master 0's read granted in the previous cycle.
REQ-011 SHALL have ports m1_en, m1_addr, m1_d, m1_we, m1_gnt, m1_q, m1_rvalid with the same directions, widths and meanings as the m0 ports, for master 1 (debug/loader master).
REQ-012 SHALL have port s_en  output  1  slave bus enable to the memory/device decoder.
REQ-013 SHALL have ports s_addr (output, 32), s_d (output, 32), s_we (output, 4): the slave address, write data and byte enables.
REQ-014 SHALL have port s_q  input  32  slave read data, valid one cycle after an enabled read (synchronous RAM timing).

Function
REQ-015 SHALL hold registered state: owner in {IDLE, OWN0, OWN1}, a 4-bit burst counter cnt, and a round-robin pointer rr (1 bit).
REQ-016 SHALL compute grants combinationally from the current m*_en and the registered state, with at most one of m0_gnt or m1_gnt high in any cycle.
REQ-017 SHALL grant nothing when neither m0_en nor m1_en is high, and drive s_en=0, s_we=0.
REQ-018 SHALL, when exactly one mX_en is high, grant mX.
REQ-019 SHALL, when both requests are high and owner=OWNx with cnt<MAX_BURST, grant x.
REQ-020 SHALL, when both requests are high and owner=OWNx with cnt==MAX_BURST, grant the other master.
REQ-021 SHALL, when both requests are high and owner=IDLE, grant the master indicated by rr.
REQ-022 SHALL drive s_en=1 and s_addr/s_d/s_we from the granted master; with no grant, s_addr and s_d are don't-care.
REQ-023 SHALL, on a grant to x, update state as follows: owner<=OWNx; cnt<=cnt+1 (saturating at MAX_BURST) if owner was already OWNx, else cnt<=1; rr<=other master.
REQ-024 SHALL, in a cycle with no grant, set owner<=IDLE and cnt<=0, and leave rr unchanged.
REQ-025 SHALL treat an ungranted request as dropped: a master whose gnt=0 must hold en/addr/d/we stable and retry, and the arbiter stores no request.
REQ-026 SHALL register rd_pend (1 bit) and rd_id (1 bit) on each granted read (we==0); writes set rd_pend=0.
REQ-027 SHALL drive m0_q=m1_q=s_q unconditionally, and set mX_rvalid=rd_pend && rd_id==X; rvalid is never high for a write.
REQ-028 SHALL make back-to-back reads from alternating masters each return rvalid to the correct master exactly one cycle after their respective grants.

Reset
REQ-029 SHALL, while rst_n=0 and asynchronously on its falling edge, force owner=IDLE, cnt=0, rr=0 (master 0 preferred first), rd_pend=0, m0_rvalid=m1_rvalid=0.
REQ-030 SHALL discard any read in flight when reset is asserted mid-operation, with no rvalid produced after reset release.
REQ-031 SHALL keep m*_gnt and s_en combinational from m*_en during reset; masters are held idle by their own resets.

Verification
REQ-032 Reset then m0 and m1 both request simultaneously from IDLE -> m0 granted first (rr=0), and m1 granted after 4 m0 grants with MAX_BURST=4.
REQ-033 Both request continuously for 16 cycles -> grant pattern 0000111100001111, with s_addr always matching the granted master.
REQ-034 m0 read granted at cycle N with s_q=32'hDEADBEEF at N+1 -> m0_rvalid=1 and m1_rvalid=0 at N+1, and m0_q=32'hDEADBEEF.
REQ-035 m0 requests alone for 10 cycles (cnt saturates at 4), then m1 joins -> m1 granted on the next cycle.
REQ-036 m1 write (we=4'b1111, d=32'h5) followed by an m0 read -> no rvalid after the write, and m0_rvalid only after the read.
REQ-037 rst_n pulsed low one cycle after a granted read -> no rvalid on any master, and after release owner=IDLE and m0 wins a simultaneous request.
